// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder
// Sequential MIPS instruction encoder and program loader. Each request is
// taken over a valid/ready handshake and packed into a 32-bit MIPS word. The
// word is then written to the next instruction-memory address.
//
// Optional feature macro: INSTR_STREAM_VERIFY_EN. When it is defined, each
// write is followed by a read-back VERIFY cycle. A mismatch sets err_verify.
//
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   clear             sync restart: pointer/count 0, errors cleared, IDLE
//   req_*             request handshake and instruction fields
//   mem_we/addr/wdata instruction-memory write port
//   mem_rdata         combinational read-back for mem_addr (verify only)
//   count, full       words written so far, count == DEPTH
//   err_illegal       sticky, set by a kind-7 request
//   err_verify        sticky read-back mismatch (0 without the feature)
//
// state  | meaning
// IDLE   | ready for a request
// WRITE  | one-cycle write strobe to mem_addr
// VERIFY | read-back compare of the word just written
// FULL   | DEPTH words written; waits for clear or reset
module instr_stream_encoder #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [5:0]        req_funct,
  input  logic [15:0]       req_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_illegal,
  output logic              err_verify
);

  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, FULL} state_t;

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W+1)'(DEPTH);

  state_t          state, nextState;
  logic            legalAccept, illegalAccept;
  logic [ADDR_W:0] countQ;
  logic            errIllegalQ;
  logic [5:0]      opcode;
  logic [4:0]      rsField;
  logic [31:0]     encWord;

  always_comb begin
    opcode  = 6'h00;
    rsField = req_rs;
    encWord = 32'h0;
    case (req_kind)
      3'd1:    opcode = 6'h08;
      3'd2:    opcode = 6'h0D;
      3'd3:    opcode = 6'h0C;
      3'd4:    opcode = 6'h0F;
      3'd5:    opcode = 6'h04;
      3'd6:    opcode = 6'h05;
      default: opcode = 6'h00;
    endcase
    // LUI has no source register; keep its rs field zero.
    if (req_kind == 3'd4) rsField = 5'd0;
    if (req_kind == 3'd0) encWord = {6'h00, req_rs, req_rt, req_rd, 5'b0, req_funct};
    else                  encWord = {opcode, rsField, req_rt, req_imm};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState     = state;
    legalAccept   = 1'b0;
    illegalAccept = 1'b0;
    case (state)
      IDLE: begin
        // clear outranks a request arriving in the same cycle
        if (!clear && req_valid) begin
          if (req_kind == 3'd7) begin
            illegalAccept = 1'b1;
          end else begin
            legalAccept = 1'b1;
            nextState   = WRITE;
          end
        end
      end
      WRITE: begin
        if (clear) nextState = IDLE;
`ifdef INSTR_STREAM_VERIFY_EN
        else       nextState = VERIFY;
`else
        // count increments on this same edge, so look one word ahead
        else       nextState = (countQ + 1'b1 == DepthCnt) ? FULL : IDLE;
`endif
      end
      VERIFY: begin
        if (clear) nextState = IDLE;
        else       nextState = (countQ == DepthCnt) ? FULL : IDLE;
      end
      FULL: begin
        if (clear) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      countQ      <= '0;
      errIllegalQ <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 32'h0;
    end else if (clear) begin
      countQ      <= '0;
      errIllegalQ <= 1'b0;
    end else begin
      if (state == WRITE) countQ <= countQ + 1'b1;
      if (illegalAccept)  errIllegalQ <= 1'b1;
      if (legalAccept) begin
        // The pointer equals count because it never wraps.
        mem_addr  <= countQ[ADDR_W-1:0];
        mem_wdata <= encWord;
      end
    end
  end

`ifdef INSTR_STREAM_VERIFY_EN
  logic errVerifyQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      errVerifyQ <= 1'b0;
    else if (clear) errVerifyQ <= 1'b0;
    else if (state == VERIFY && mem_rdata != mem_wdata) errVerifyQ <= 1'b1;
  end

  assign err_verify = errVerifyQ;
`else
  logic unusedRdata;
  assign unusedRdata = ^mem_rdata;
  assign err_verify  = 1'b0;
`endif

  assign req_ready   = (state == IDLE);
  assign mem_we      = (state == WRITE);
  assign count       = countQ;
  assign full        = (countQ == DepthCnt);
  assign err_illegal = errIllegalQ;

endmodule

// File: tb/tb_instr_stream_encoder.sv
module tb_instr_stream_encoder;

  logic        clk = 1'b0;
  logic        reset, clear, req_valid, req_ready;
  logic [2:0]  req_kind;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [5:0]  req_funct;
  logic [15:0] req_imm;
  logic        mem_we;
  logic [1:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [2:0]  count;
  logic        full, err_illegal, err_verify;

  logic [31:0] memArr [4];
  logic        corrupt;

  int errors = 0;
  int checks = 0;

`ifdef INSTR_STREAM_VERIFY_EN
  localparam logic [31:0] VerifyExp = 32'd1;
`else
  localparam logic [31:0] VerifyExp = 32'd0;
`endif

  instr_stream_encoder #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_funct(req_funct), .req_imm(req_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .count(count), .full(full),
    .err_illegal(err_illegal), .err_verify(err_verify)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) memArr[mem_addr] <= mem_wdata;
  assign mem_rdata = memArr[mem_addr] ^ {31'b0, corrupt};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Returns #1 after the accepting edge, i.e. inside the WRITE cycle.
  task automatic doReq(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm);
    int n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    check("ready_wait", {31'b0, req_ready}, 32'd1);
    req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd; req_funct = fn; req_imm = imm;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) memArr[i] = 32'h0;
    reset = 1'b1; clear = 1'b0; req_valid = 1'b0; corrupt = 1'b0;
    req_kind = 3'd0; req_rs = 5'd0; req_rt = 5'd0; req_rd = 5'd0;
    req_funct = 6'd0; req_imm = 16'd0;
    #12 reset = 1'b0;
    step();
    check("rst_we",      {31'b0, mem_we},      32'd0);
    check("rst_addr",    {30'b0, mem_addr},    32'd0);
    check("rst_wdata",   mem_wdata,            32'd0);
    check("rst_count",   {29'b0, count},       32'd0);
    check("rst_full",    {31'b0, full},        32'd0);
    check("rst_illegal", {31'b0, err_illegal}, 32'd0);
    check("rst_verify",  {31'b0, err_verify},  32'd0);
    check("rst_ready",   {31'b0, req_ready},   32'd1);

    doReq(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0005);
    check("addi_we",    {31'b0, mem_we},    32'd1);
    check("addi_addr",  {30'b0, mem_addr},  32'd0);
    check("addi_wdata", mem_wdata,          32'h20080005);
    check("addi_ready", {31'b0, req_ready}, 32'd0);
    step();
    check("addi_count", {29'b0, count},     32'd1);
    check("addi_we_off", {31'b0, mem_we},   32'd0);
    check("addi_addr_hold", {30'b0, mem_addr}, 32'd0);

    doReq(3'd0, 5'd9, 5'd10, 5'd8, 6'h20, 16'h0000);
    check("rtype_addr",  {30'b0, mem_addr}, 32'd1);
    check("rtype_wdata", mem_wdata,         32'h012A4020);
    step();
    check("rtype_count", {29'b0, count},    32'd2);

    doReq(3'd7, 5'd1, 5'd2, 5'd3, 6'd0, 16'h1234);
    check("ill_we",      {31'b0, mem_we},      32'd0);
    check("ill_flag",    {31'b0, err_illegal}, 32'd1);
    check("ill_count",   {29'b0, count},       32'd2);
    check("ill_ready",   {31'b0, req_ready},   32'd1);
    check("ill_wdata",   mem_wdata,            32'h012A4020);

    doReq(3'd4, 5'd5, 5'd1, 5'd0, 6'd0, 16'h1001);
    check("lui_addr",  {30'b0, mem_addr}, 32'd2);
    check("lui_wdata", mem_wdata,         32'h3C011001);
    step();

    doReq(3'd6, 5'd8, 5'd9, 5'd0, 6'd0, 16'hFFFE);
    check("bne_addr",  {30'b0, mem_addr}, 32'd3);
    check("bne_wdata", mem_wdata,         32'h1509FFFE);
    step();
    check("full_count", {29'b0, count},    32'd4);
    check("full_flag",  {31'b0, full},     32'd1);
    check("full_ready", {31'b0, req_ready}, 32'd0);
    step();
    check("full_verify_clean", {31'b0, err_verify}, 32'd0);

    req_kind = 3'd1; req_rs = 5'd3; req_rt = 5'd4; req_imm = 16'h5555;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("held_we", {31'b0, mem_we}, 32'd0);
    end
    check("held_count", {29'b0, count},     32'd4);
    check("held_ready", {31'b0, req_ready}, 32'd0);
    check("held_wdata", mem_wdata,          32'h1509FFFE);
    check("held_illegal", {31'b0, err_illegal}, 32'd1);
    req_valid = 1'b0;

    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_count",   {29'b0, count},       32'd0);
    check("clr_full",    {31'b0, full},        32'd0);
    check("clr_illegal", {31'b0, err_illegal}, 32'd0);
    check("clr_ready",   {31'b0, req_ready},   32'd1);

    doReq(3'd2, 5'd2, 5'd3, 5'd0, 6'd0, 16'h00FF);
    check("ori_addr",  {30'b0, mem_addr}, 32'd0);
    check("ori_wdata", mem_wdata,         32'h344300FF);
    clear = 1'b1;
    check("clrw_we", {31'b0, mem_we}, 32'd1);
    step();
    clear = 1'b0;
    check("clrw_count", {29'b0, count},     32'd0);
    check("clrw_we_off", {31'b0, mem_we},   32'd0);
    check("clrw_ready", {31'b0, req_ready}, 32'd1);

    corrupt = 1'b1;
    doReq(3'd3, 5'd4, 5'd5, 5'd0, 6'd0, 16'h0F0F);
    check("andi_addr",  {30'b0, mem_addr}, 32'd0);
    check("andi_wdata", mem_wdata,         32'h30850F0F);
    step();
    step();
    check("verify_flag",  {31'b0, err_verify}, VerifyExp);
    check("verify_count", {29'b0, count},      32'd1);
    corrupt = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("verify_clr", {31'b0, err_verify}, 32'd0);

    doReq(3'd5, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0003);
    check("beq_addr",  {30'b0, mem_addr}, 32'd0);
    check("beq_wdata", mem_wdata,         32'h10220003);
    step();
    check("beq_count", {29'b0, count},    32'd1);

    reset = 1'b1;
    #1;
    check("async_rst_count", {29'b0, count}, 32'd0);
    check("async_rst_wdata", mem_wdata,      32'd0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
